keypad_scanner: RTL and testbench

- Matrix-keypad front end that produces the 10-bit push-button pulse vector consumed by the calculator top level's pb input. It is the transmitting side of the pb interface.
- Drives a 2-column x 5-row key matrix and synchronises and debounces the row returns.
- Emits exactly one single-cycle pb pulse per clean key press, plus a registered key code for debug and display.

---
 rtl/keypad_scanner.sv | 262 ++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Front end for a 2-column x 5-row key matrix. It drives the columns one at a
// time, synchronises and debounces the row returns, and produces a one-hot,
// single-cycle push-button pulse vector for the calculator's pb input.
//
// Parameters:
//   SCAN_DIV  clock cycles each column is driven before its rows are sampled
//             (must be >= 4 so the 2-flop synchroniser settles first)
//   DEBOUNCE  consecutive identical scan frames needed to accept a press or a
//             release (1..15)
//
// Ports:
//   clk        system clock
//   nrst       asynchronous active-low reset
//   rows[4:0]  row returns, active-low, pulled up, asynchronous to clk
//   cols[1:0]  column drives, active-low, exactly one bit low at all times
//   pb[9:0]    one-hot single-cycle key pulse, bit index = col*5 + row
//   key_valid  high while an accepted key is held or its release is debounced
//   key_code   index 0..9 of the last accepted key, kept after release
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [4:0] rows,
  output logic [1:0] cols,
  output logic [9:0] pb,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // The counter is compared before incrementing, so the accepting frame is
  // the one that arrives while the count still reads DEBOUNCE-1.
  localparam logic [CNT_W-1:0] CNT_HIT  = CNT_W'(DEBOUNCE - 1);
  localparam bit               DB_ONE   = (DEBOUNCE == 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchroniser: two flops per row, reset to the idle (pulled-up) level.
  // ---------------------------------------------------------------------------
  logic [4:0] rows_sync;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= rows[gi];
          s2_reg <= s1_reg;
        end
      end

      assign rows_sync[gi] = s2_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scan divider and column drive.
  // col_reg is the index of the driven column; cols_reg is its active-low
  // one-hot image so the output comes straight from a flop.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_reg;
  logic             col_reg;
  logic [1:0]       cols_reg;
  logic             frame_reg;   // one-cycle strobe: a full frame is in snapshot
  logic             sample;

  assign sample = (div_reg == DIV_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_reg   <= '0;
      col_reg   <= 1'b0;
      cols_reg  <= 2'b10;
      frame_reg <= 1'b0;
    end else begin
      frame_reg <= 1'b0;
      if (sample) begin
        div_reg   <= '0;
        col_reg   <= ~col_reg;
        cols_reg  <= ~cols_reg;
        // Sampling column 1 completes the frame; evaluate it next cycle.
        frame_reg <= col_reg;
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot: each column stores its inverted (active-high) row sample when
  // the divider expires while that column is driven.
  // ---------------------------------------------------------------------------
  logic [9:0] snapshot;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_snap
      logic [4:0] snap_reg;

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          snap_reg <= '0;
        end else if (sample && (col_reg == 1'(gi))) begin
          snap_reg <= ~rows_sync;
        end
      end

      assign snapshot[gi*5 +: 5] = snap_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame classification. hit_cnt saturates at 2, which is all the FSM needs
  // to tell NONE, SINGLE and MULTI apart; hit_idx is only meaningful for SINGLE.
  // ---------------------------------------------------------------------------
  logic [1:0] hit_cnt;
  logic [3:0] hit_idx;
  logic       is_none;
  logic       is_single;

  always_comb begin
    hit_cnt = 2'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (snapshot[i]) begin
        if (hit_cnt != 2'd2) begin
          hit_cnt = hit_cnt + 2'd1;
        end
        hit_idx = 4'(i);
      end
    end
  end

  assign is_none   = (hit_cnt == 2'd0);
  assign is_single = (hit_cnt == 2'd1);

  // ---------------------------------------------------------------------------
  // Debounce FSM, stepped once per frame. pb, key_valid and key_code are
  // registered here so every output changes on the same edge as the state.
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [3:0]       cand_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [9:0]       pb_reg;
  logic             key_valid_reg;
  logic [3:0]       key_code_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      cand_reg      <= 4'd0;
      cnt_reg       <= '0;
      pb_reg        <= '0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'd0;
    end else begin
      // pb is a strobe: cleared every cycle unless a press is accepted now.
      pb_reg <= '0;
      if (frame_reg) begin
        unique case (state_reg)
          IDLE: begin
            if (is_single) begin
              cand_reg <= hit_idx;
              if (DB_ONE) begin
                state_reg     <= HELD;
                cnt_reg       <= '0;
                pb_reg        <= 10'(1) << hit_idx;
                key_code_reg  <= hit_idx;
                key_valid_reg <= 1'b1;
              end else begin
                state_reg <= PRESS_DB;
                cnt_reg   <= CNT_W'(1);
              end
            end
          end

          PRESS_DB: begin
            if (is_single && (hit_idx == cand_reg)) begin
              if (cnt_reg == CNT_HIT) begin
                state_reg     <= HELD;
                cnt_reg       <= '0;
                pb_reg        <= 10'(1) << cand_reg;
                key_code_reg  <= cand_reg;
                key_valid_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
              end
            end else if (is_single) begin
              // A different key took over: restart the count on it.
              cand_reg <= hit_idx;
              cnt_reg  <= CNT_W'(1);
            end else begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end
          end

          HELD: begin
            // MULTI and SINGLE frames both mean "still pressed".
            if (is_none) begin
              if (DB_ONE) begin
                state_reg     <= IDLE;
                cnt_reg       <= '0;
                key_valid_reg <= 1'b0;
              end else begin
                state_reg <= REL_DB;
                cnt_reg   <= CNT_W'(1);
              end
            end
          end

          REL_DB: begin
            if (is_none) begin
              if (cnt_reg == CNT_HIT) begin
                state_reg     <= IDLE;
                cnt_reg       <= '0;
                key_valid_reg <= 1'b0;
              end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
              end
            end else begin
              // Release glitch: any key seen puts us back in HELD, no pulse.
              state_reg <= HELD;
              cnt_reg   <= '0;
            end
          end

          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign cols      = cols_reg;
  assign pb        = pb_reg;
  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives a simulated key matrix (a 10-bit set of pressed keys, changed only at
// frame boundaries) into keypad_scanner with SCAN_DIV=4, DEBOUNCE=3. A
// frame-level reference model tracks run lengths of identical SINGLE frames and
// of NONE frames to predict the pulse, key_valid and key_code after each
// frame evaluation. Directed scenarios are followed by random key patterns.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FRAME = 2 * SD;

  logic       clk;
  logic       nrst;
  logic [4:0] rows;
  logic [1:0] cols;
  logic [9:0] pb;
  logic       key_valid;
  logic [3:0] key_code;

  logic [9:0] keys;

  int total;
  int bad;
  int frame_no;

  // Reference model state
  int         single_run;
  int         single_key;
  int         none_run;
  bit         m_held;
  logic [9:0] exp_pb;
  logic       exp_valid;
  logic [3:0] exp_code;

  keypad_scanner #(
    .SCAN_DIV (SD),
    .DEBOUNCE (DB)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rows      (rows),
    .cols      (cols),
    .pb        (pb),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven.
  assign rows = (cols == 2'b01) ? ~keys[9:5] : ~keys[4:0];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    single_run = 0;
    single_key = -1;
    none_run   = 0;
    m_held     = 1'b0;
    exp_pb     = '0;
    exp_valid  = 1'b0;
    exp_code   = 4'd0;
  endtask

  // Predict the result of evaluating one frame whose pressed-key set is k.
  task automatic model_frame(input logic [9:0] k);
    int pop;
    int idx;
    pop = $countones(k);
    idx = 0;
    for (int i = 0; i < 10; i++) if (k[i]) idx = i;
    exp_pb = '0;
    if (pop == 0) begin
      none_run++;
      single_run = 0;
    end else if (pop == 1) begin
      none_run = 0;
      if (single_run > 0 && single_key == idx) single_run++;
      else begin
        single_run = 1;
        single_key = idx;
      end
    end else begin
      none_run = 0;
      single_run = 0;
    end
    if (!m_held) begin
      if (single_run >= DB) begin
        m_held   = 1'b1;
        exp_pb   = k;
        exp_code = 4'(idx);
      end
    end else if (none_run >= DB) begin
      m_held = 1'b0;
    end
    exp_valid = m_held;
  endtask

  // One scan frame with key set k. Entered right after the edge that starts
  // column 0; the previous frame's evaluation shows on the first sample.
  task automatic frame(input logic [9:0] k);
    logic [9:0] pb_prev;
    logic       v_prev;
    logic [3:0] c_prev;
    logic [1:0] ec;
    logic [9:0] seen;
    pb_prev = exp_pb;
    v_prev  = exp_valid;
    c_prev  = exp_code;
    keys    = k;
    model_frame(k);
    seen = '0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk);
      #1;
      ec = (i >= SD - 1 && i <= FRAME - 2) ? 2'b01 : 2'b10;
      chk("cols", 16'(cols), 16'(ec));
      seen = seen | pb;
      if (i == 0) begin
        chk("pb_pulse", 16'(pb), 16'(pb_prev));
        chk("key_valid", 16'(key_valid), 16'(v_prev));
        chk("key_code", 16'(key_code), 16'(c_prev));
      end else begin
        chk("pb_quiet", 16'(pb), 16'd0);
      end
    end
    $display("frame %0d keys=%010b pb_seen=%010b valid=%0b code=%0d",
             frame_no, k, seen, key_valid, key_code);
    frame_no++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("rst_cols", 16'(cols), 16'h2);
    chk("rst_pb", 16'(pb), 16'd0);
    chk("rst_valid", 16'(key_valid), 16'd0);
    chk("rst_code", 16'(key_code), 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_cols", 16'(cols), 16'h2);
    chk("rst_hold_pb", 16'(pb), 16'd0);
    nrst = 1'b1;
    model_reset();
    $display("reset released at frame %0d", frame_no);
  endtask

  task automatic frames(input logic [9:0] k, input int n);
    for (int i = 0; i < n; i++) frame(k);
  endtask

  initial begin
    logic [9:0] k;
    int sel;
    int len;
    int a;
    int b;
    total    = 0;
    bad      = 0;
    frame_no = 0;
    nrst     = 1'b0;
    keys     = '0;
    model_reset();

    do_reset();
    frames(10'd0, 2);

    // Clean press of key 7 (col1,row2), then release
    frames(10'b0010000000, 5);
    frames(10'd0, 4);

    // Bounce on key 3, then steady hold
    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 10'b0000001000 : 10'd0);
    frames(10'b0000001000, 4);
    frames(10'd0, 4);

    // Key 0 held, key 9 added from frame 5
    frames(10'b0000000001, 5);
    frames(10'b1000000001, 15);
    frames(10'd0, 4);

    // Release glitch on key 4
    frames(10'b0000010000, 4);
    frames(10'd0, 2);
    frames(10'b0000010000, 1);
    frames(10'd0, 3);
    frames(10'd0, 1);

    // Reset while debouncing key 5 at count 2
    frames(10'b0000100000, 2);
    @(posedge clk);
    #1;
    chk("pre_reset_pb", 16'(pb), 16'd0);
    do_reset();
    frames(10'b0000100000, 4);
    frames(10'd0, 4);

    // Random key patterns held for 1..5 frames each
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 99);
      a = $urandom_range(0, 9);
      b = (a + $urandom_range(1, 9)) % 10;
      if (sel < 35) k = '0;
      else if (sel < 85) k = 10'(1) << a;
      else k = (10'(1) << a) | (10'(1) << b);
      len = $urandom_range(1, 5);
      frames(k, len);
    end
    frames(10'd0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
